// File: rtl/vga_tile_timing_if.sv
// Signal bundle between the VGA tile timing generator (master) and the
// world/graphics consumers (slave).
interface vga_tile_timing_if #(
    parameter int CNT_W     = 10,
    parameter int TILE_LOG2 = 5
);
    logic                       pix_en;
    logic                       vga_hs;
    logic                       vga_vs;
    logic                       video_on;
    logic [CNT_W-1:0]           pixel_x;
    logic [CNT_W-1:0]           pixel_y;
    logic [CNT_W-TILE_LOG2-1:0] tile_col;
    logic [CNT_W-TILE_LOG2-1:0] tile_row;
    logic [TILE_LOG2-1:0]       tile_px;
    logic [TILE_LOG2-1:0]       tile_py;
    logic                       line_tick;
    logic                       frame_tick;
    logic [7:0]                 frame_count;

    modport master (
        input  pix_en,
        output vga_hs, vga_vs, video_on,
        output pixel_x, pixel_y,
        output tile_col, tile_row, tile_px, tile_py,
        output line_tick, frame_tick, frame_count
    );

    modport slave (
        output pix_en,
        input  vga_hs, vga_vs, video_on,
        input  pixel_x, pixel_y,
        input  tile_col, tile_row, tile_px, tile_py,
        input  line_tick, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_tile_timing.sv
// Parametrised VGA timing with tile coordinates, line/frame strobes and a
// pixel-enable aligned sync delay. VGA_TILE_FRAME_CNT_EN enables frame_count.
module vga_tile_timing #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int CNT_W       = 10,
    parameter int TILE_LOG2   = 5,
    parameter int ALIGN_DELAY = 2
) (
    input  logic              clock_50,
    input  logic              reset,
    vga_tile_timing_if.master vid
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_STOP  = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_STOP  = VS_START + V_SYNC;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int PIPE_W   = ALIGN_DELAY + 1;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);

    // Refuse to build a configuration whose counters would silently wrap early.
    generate
        if ((H_TOTAL - 1) > CNT_MAX || (V_TOTAL - 1) > CNT_MAX) begin : g_bad_cnt_w
            $error("vga_tile_timing: CNT_W=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d",
                   CNT_W, H_TOTAL, V_TOTAL);
        end
        if (TILE_LOG2 < 1 || TILE_LOG2 >= CNT_W) begin : g_bad_tile
            $error("vga_tile_timing: TILE_LOG2=%0d must lie in 1..CNT_W-1", TILE_LOG2);
        end
        if (ALIGN_DELAY < 0 || ALIGN_DELAY > 3) begin : g_bad_align
            $error("vga_tile_timing: ALIGN_DELAY=%0d must lie in 0..3", ALIGN_DELAY);
        end
    endgenerate

    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0]  pixel_x_q, pixel_y_q;
    logic [PIPE_W-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_W-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_W-1:0] vid_pipe_q, vid_pipe_d;
    logic              line_tick_q, frame_tick_q;

    logic        h_last, v_last, frame_end;
    logic        hs_raw, vs_raw, vid_raw;
    logic        hs_lvl, vs_lvl;
    logic [31:0] h_wide, v_wide;

    // Stage 0 of each pipe is decoded from the same counter value that lands
    // in pixel_x/pixel_y, so ALIGN_DELAY=0 keeps sync and coordinates aligned.
    always_comb begin
        h_wide    = 32'(h_cnt_q);
        v_wide    = 32'(v_cnt_q);
        h_last    = (h_cnt_q == H_LAST);
        v_last    = (v_cnt_q == V_LAST);
        frame_end = h_last && (v_cnt_q == V_ACT_LAST);

        hs_raw  = (h_wide >= HS_START) && (h_wide < HS_STOP);
        vs_raw  = (v_wide >= VS_START) && (v_wide < VS_STOP);
        vid_raw = (h_wide < H_ACTIVE) && (v_wide < V_ACTIVE);
        hs_lvl  = hs_raw ? HS_POL : ~HS_POL;
        vs_lvl  = vs_raw ? VS_POL : ~VS_POL;

        h_cnt_d = h_last ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
        end

        hs_pipe_d  = PIPE_W'({hs_pipe_q, hs_lvl});
        vs_pipe_d  = PIPE_W'({vs_pipe_q, vs_lvl});
        vid_pipe_d = PIPE_W'({vid_pipe_q, vid_raw});
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pixel_x_q    <= '0;
            pixel_y_q    <= '0;
            hs_pipe_q    <= {PIPE_W{~HS_POL}};
            vs_pipe_q    <= {PIPE_W{~VS_POL}};
            vid_pipe_q   <= '0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            line_tick_q  <= vid.pix_en && h_last;
            frame_tick_q <= vid.pix_en && frame_end;
            if (vid.pix_en) begin
                h_cnt_q    <= h_cnt_d;
                v_cnt_q    <= v_cnt_d;
                pixel_x_q  <= h_cnt_q;
                pixel_y_q  <= v_cnt_q;
                hs_pipe_q  <= hs_pipe_d;
                vs_pipe_q  <= vs_pipe_d;
                vid_pipe_q <= vid_pipe_d;
            end
        end
    end

    assign vid.vga_hs     = hs_pipe_q[PIPE_W-1];
    assign vid.vga_vs     = vs_pipe_q[PIPE_W-1];
    assign vid.video_on   = vid_pipe_q[PIPE_W-1];
    assign vid.pixel_x    = pixel_x_q;
    assign vid.pixel_y    = pixel_y_q;
    assign vid.tile_col   = pixel_x_q[CNT_W-1:TILE_LOG2];
    assign vid.tile_row   = pixel_y_q[CNT_W-1:TILE_LOG2];
    assign vid.tile_px    = pixel_x_q[TILE_LOG2-1:0];
    assign vid.tile_py    = pixel_y_q[TILE_LOG2-1:0];
    assign vid.line_tick  = line_tick_q;
    assign vid.frame_tick = frame_tick_q;

`ifdef VGA_TILE_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Counts on the same edge that raises frame_tick, wrapping 255 -> 0.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (vid.pix_en && frame_end) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vid.frame_count = frame_cnt_q;
`else
    assign vid.frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_tile_timing.sv
// Directed bench for vga_tile_timing: one DUT with default horizontal timing
// and a short frame, plus a tiny active-high instance for frame_count wrap.
module tb_vga_tile_timing;
    logic clock_50 = 1'b0;
    logic reset    = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    vga_tile_timing_if #(.CNT_W(10), .TILE_LOG2(5)) busA ();
    vga_tile_timing_if #(.CNT_W(4),  .TILE_LOG2(1)) busB ();

    vga_tile_timing #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(40),  .V_FP(2),  .V_SYNC(2),  .V_BP(2),
        .HS_POL(1'b0),  .VS_POL(1'b0),
        .CNT_W(10), .TILE_LOG2(5), .ALIGN_DELAY(2)
    ) dutA (
        .clock_50(clock_50),
        .reset   (reset),
        .vid     (busA)
    );

    vga_tile_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .CNT_W(4), .TILE_LOG2(1), .ALIGN_DELAY(0)
    ) dutB (
        .clock_50(clock_50),
        .reset   (reset),
        .vid     (busB)
    );

    always #5 clock_50 = ~clock_50;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enA, input logic enB);
        busA.pix_en = enA;
        busB.pix_en = enB;
        @(posedge clock_50);
        #1;
    endtask

    // k = index of the most recent pix_en since reset; afterEdge is set when
    // that pix_en was taken on the edge just before this sample.
    task automatic checkA(input int k, input bit afterEdge);
        int   x, y, jx, jy, ticks, fc;
        logic expHs, expVs, expVid, expLine, expFrame;
        x = k % 800;
        y = (k / 800) % 46;
        if (k < 2) begin
            expHs  = 1'b1;
            expVs  = 1'b1;
            expVid = 1'b0;
        end else begin
            jx     = (k - 2) % 800;
            jy     = ((k - 2) / 800) % 46;
            expHs  = !(jx >= 656 && jx < 752);
            expVs  = !(jy >= 42 && jy < 44);
            expVid = (jx < 640) && (jy < 40);
        end
        expLine  = afterEdge && (x == 799);
        expFrame = afterEdge && ((k % 36800) == 31999);
        ticks    = (k >= 31999) ? 1 + (k - 31999) / 36800 : 0;
`ifdef VGA_TILE_FRAME_CNT_EN
        fc = ticks % 256;
`else
        fc = 0 * ticks;
`endif
        checkOutput("A.pixel_x",     32'(busA.pixel_x),     x);
        checkOutput("A.pixel_y",     32'(busA.pixel_y),     y);
        checkOutput("A.tile_col",    32'(busA.tile_col),    x / 32);
        checkOutput("A.tile_row",    32'(busA.tile_row),    y / 32);
        checkOutput("A.tile_px",     32'(busA.tile_px),     x % 32);
        checkOutput("A.tile_py",     32'(busA.tile_py),     y % 32);
        checkOutput("A.vga_hs",      32'(busA.vga_hs),      32'(expHs));
        checkOutput("A.vga_vs",      32'(busA.vga_vs),      32'(expVs));
        checkOutput("A.video_on",    32'(busA.video_on),    32'(expVid));
        checkOutput("A.line_tick",   32'(busA.line_tick),   32'(expLine));
        checkOutput("A.frame_tick",  32'(busA.frame_tick),  32'(expFrame));
        checkOutput("A.frame_count", 32'(busA.frame_count), fc);
    endtask

    task automatic checkB(input int k);
        int x, y, ticks, fc;
        x     = k % 7;
        y     = (k / 7) % 5;
        ticks = (k >= 13) ? 1 + (k - 13) / 35 : 0;
`ifdef VGA_TILE_FRAME_CNT_EN
        fc = ticks % 256;
`else
        fc = 0 * ticks;
`endif
        checkOutput("B.pixel_x",     32'(busB.pixel_x),     x);
        checkOutput("B.pixel_y",     32'(busB.pixel_y),     y);
        checkOutput("B.tile_col",    32'(busB.tile_col),    x / 2);
        checkOutput("B.tile_px",     32'(busB.tile_px),     x % 2);
        checkOutput("B.tile_row",    32'(busB.tile_row),    y / 2);
        checkOutput("B.tile_py",     32'(busB.tile_py),     y % 2);
        checkOutput("B.vga_hs",      32'(busB.vga_hs),      32'(x == 5));
        checkOutput("B.vga_vs",      32'(busB.vga_vs),      32'(y == 3));
        checkOutput("B.video_on",    32'(busB.video_on),    32'(x < 4 && y < 2));
        checkOutput("B.line_tick",   32'(busB.line_tick),   32'(x == 6));
        checkOutput("B.frame_tick",  32'(busB.frame_tick),  32'((k % 35) == 13));
        checkOutput("B.frame_count", 32'(busB.frame_count), fc);
    endtask

    initial begin
        busA.pix_en = 1'b0;
        busB.pix_en = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clock_50);
        #1;
        checkOutput("reset.pixel_x",    32'(busA.pixel_x),    0);
        checkOutput("reset.pixel_y",    32'(busA.pixel_y),    0);
        checkOutput("reset.vga_hs",     32'(busA.vga_hs),     1);
        checkOutput("reset.vga_vs",     32'(busA.vga_vs),     1);
        checkOutput("reset.video_on",   32'(busA.video_on),   0);
        checkOutput("reset.line_tick",  32'(busA.line_tick),  0);
        checkOutput("reset.frame_tick", 32'(busA.frame_tick), 0);
        checkOutput("reset.B_vga_hs",   32'(busB.vga_hs),     0);
        reset = 1'b0;

        // pix_en on every second clock for one full line
        for (int k = 0; k < 800; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkA(k, 1'b1);
            applyStimulus(1'b0, 1'b0);
            checkA(k, 1'b0);
        end

        // pix_en constantly high through a full frame into the next one
        for (int k = 800; k <= 38700; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkA(k, 1'b1);
            if (k == 37 * 800 + 100) begin
                checkOutput("tile.col", 32'(busA.tile_col), 3);
                checkOutput("tile.row", 32'(busA.tile_row), 1);
                checkOutput("tile.px",  32'(busA.tile_px),  4);
                checkOutput("tile.py",  32'(busA.tile_py),  5);
            end
            if (k == 31999) begin
                checkOutput("first_frame_tick", 32'(busA.frame_tick), 1);
            end
            if (k == 20400) begin
                for (int h = 0; h < 50; h++) begin
                    applyStimulus(1'b0, 1'b0);
                    checkA(k, 1'b0);
                end
            end
        end

        // asynchronous reset mid-line, then restart from the top
        checkOutput("pre_reset.pixel_x",  32'(busA.pixel_x),  300);
        checkOutput("pre_reset.pixel_y",  32'(busA.pixel_y),  2);
        checkOutput("pre_reset.video_on", 32'(busA.video_on), 1);
        busA.pix_en = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("async_reset.pixel_x",     32'(busA.pixel_x),     0);
        checkOutput("async_reset.pixel_y",     32'(busA.pixel_y),     0);
        checkOutput("async_reset.tile_col",    32'(busA.tile_col),    0);
        checkOutput("async_reset.video_on",    32'(busA.video_on),    0);
        checkOutput("async_reset.vga_hs",      32'(busA.vga_hs),      1);
        checkOutput("async_reset.vga_vs",      32'(busA.vga_vs),      1);
        checkOutput("async_reset.frame_count", 32'(busA.frame_count), 0);
        @(posedge clock_50);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkA(k, 1'b1);
        end

        // small instance: 257 frames covers the frame_count wrap
        for (int k = 0; k < 35 * 257; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkB(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_tile_timing.md
Name: vga_tile_timing

Overview:
Parametrised successor to the fixed 640x480 sync path. It generates VGA horizontal and vertical timing from a single system clock plus a pixel-enable strobe. It also derives tile coordinates for the world/sprite lookup and emits line and frame strobes for game-state updates. Sync and video_on can be delayed to match the latency of the graphics pipeline. It sits between the top level and the world/graphics blocks and replaces the hard-coded sync generator.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active low)
VS_POL, 0, vsync active level (0 = active low)
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
TILE_LOG2, 5, tile edge = 2**TILE_LOG2 pixels
ALIGN_DELAY, 2, extra pixel-enable stages on vga_hs, vga_vs and video_on (0..3)

Ports:
clock_50  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
pix_en  in  1  pixel strobe; counters and delay stages advance only when high
vga_hs  out  1  horizontal sync, polarity per HS_POL
vga_vs  out  1  vertical sync, polarity per VS_POL
video_on  out  1  high inside the active area
pixel_x  out  CNT_W  current horizontal count
pixel_y  out  CNT_W  current vertical count
tile_col  out  CNT_W-TILE_LOG2  pixel_x >> TILE_LOG2
tile_row  out  CNT_W-TILE_LOG2  pixel_y >> TILE_LOG2
tile_px  out  TILE_LOG2  pixel_x[TILE_LOG2-1:0]
tile_py  out  TILE_LOG2  pixel_y[TILE_LOG2-1:0]
line_tick  out  1  one-clock pulse at end of each line
frame_tick  out  1  one-clock pulse at start of vertical blank
frame_count  out  8  frame counter (see Optional Feature)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h_cnt advances 0..H_TOTAL-1 on each pix_en and wraps to 0.
- v_cnt increments when h_cnt wraps; v_cnt wraps from V_TOTAL-1 to 0.
- Sync window: hsync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync uses the same rule on v_cnt with the V_ parameters.
- video_on is asserted when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Registered outputs: pixel_x, pixel_y and the tile_* fields are registered and reflect the counters one clock after the pix_en that produced them. They update only on pix_en.
- Alignment delay: vga_hs, vga_vs and video_on pass through an ALIGN_DELAY-deep shift chain. The chain shifts only on pix_en. With ALIGN_DELAY=0 these outputs are time-aligned with pixel_x/pixel_y.
- line_tick: high for exactly one clock_50 cycle, on the clock after the pix_en where h_cnt wraps H_TOTAL-1 -> 0.
- frame_tick: high for exactly one cycle, on the clock after the pix_en where h_cnt = H_TOTAL-1 and v_cnt = V_ACTIVE-1. Both ticks are undelayed.
- pix_en low holds every register, including the delay chain; both ticks are 0 while it is low.
- Reset (asynchronous, any time including mid-frame):
  - counters, pixel_x, pixel_y and tile_* go to 0;
  - the delay chain and vga_hs/vga_vs go to the inactive level (~HS_POL, ~VS_POL);
  - video_on, line_tick and frame_tick go to 0; frame_count goes to 0.
- Restart after reset: the first pix_en after release yields pixel_x=0 and pixel_y=0 and restarts the frame from the top.
- Bad configuration: if H_TOTAL-1 or V_TOTAL-1 exceeds 2**CNT_W-1, the design must fail elaboration via a generate-time error.

Optional Feature:
Macro VGA_TILE_FRAME_CNT_EN.
- Defined: frame_count increments by 1 on every frame_tick and wraps 255 -> 0.
- Undefined: frame_count is tied to 0 and no counter logic is inferred.

Test Plan:
- Defaults, pix_en every 2nd clock: one line spans 1600 clocks; the hsync window is pix_en counts 656..751 with vga_hs low, delayed by 2 pix_en; line_tick occurs every 800 pix_en.
- Defaults, pix_en=1 constantly: frame_tick occurs every 420000 clocks, first at pix_en count 800*479+799; video_on is low for pixel_y 480..524; vga_vs is low for pixel_y 490..491.
- pixel_x=100, pixel_y=37, TILE_LOG2=5: tile_col=3, tile_row=1, tile_px=4, tile_py=5.
- Assert reset at pixel_x=300, pixel_y=200: all outputs return to reset values asynchronously within the same cycle; first pix_en after release gives pixel_x=0, pixel_y=0.
- Hold pix_en=0 for 50 clocks mid-line: all outputs remain constant; line_tick and frame_tick stay 0.
- With VGA_TILE_FRAME_CNT_EN defined: frame_count reads 0,1,...,255,0 across 257 frame_ticks. Undefined: frame_count stays 0.
